// File: rtl/bunch_of_reg.sv
// Three independent WIDTH-bit D registers with no enable.
// Each channel has its own synchronous, active-low reset value.
module bunch_of_reg #(
    parameter int unsigned     WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL0 = '0,
    parameter logic [WIDTH-1:0] RST_VAL1 = '0,
    parameter logic [WIDTH-1:0] RST_VAL2 = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2
);

    logic [WIDTH-1:0] r_q0;
    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    // Reset is sampled only at the clock edge, so a glitch on rst_n between edges is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q0 <= RST_VAL0;
            r_q1 <= RST_VAL1;
            r_q2 <= RST_VAL2;
        end else begin
            r_q0 <= d0;
            r_q1 <= d1;
            r_q2 <= d2;
        end
    end

    assign q0 = r_q0;
    assign q1 = r_q1;
    assign q2 = r_q2;

endmodule

// File: tb/tb_bunch_of_reg.sv
// Directed bench for bunch_of_reg: default-reset instance plus one with
// non-zero reset values, both fed from the same inputs.
module tb_bunch_of_reg;

    logic       clk;
    logic       rst_n;
    logic [7:0] d0, d1, d2;
    logic [7:0] q0, q1, q2;
    logic [7:0] p0, p1, p2;

    int n_chk  = 0;
    int n_pass = 0;

    bunch_of_reg u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .q0    (q0),
        .q1    (q1),
        .q2    (q2)
    );

    bunch_of_reg #(
        .WIDTH    (8),
        .RST_VAL0 (8'hA5),
        .RST_VAL1 (8'h3C),
        .RST_VAL2 (8'h81)
    ) u_dut_rv (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .q0    (p0),
        .q1    (p1),
        .q2    (p2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, want 0x%02h", tag, obs, exp);
    endtask

    task automatic check_q(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2);
        check_val({tag, " q0"}, q0, e0);
        check_val({tag, " q1"}, q1, e1);
        check_val({tag, " q2"}, q2, e2);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] vec [3][3];

    initial begin
        vec[0][0] = 8'h00; vec[0][1] = 8'hFF; vec[0][2] = 8'h5A;
        vec[1][0] = 8'hFF; vec[1][1] = 8'h00; vec[1][2] = 8'hA5;
        vec[2][0] = 8'h80; vec[2][1] = 8'h01; vec[2][2] = 8'h7E;

        rst_n = 1'b0;
        d0 = 8'h01; d1 = 8'h0F; d2 = 8'hF0;
        tick();
        check_q("reset", 8'h00, 8'h00, 8'h00);
        check_val("rstval p0", p0, 8'hA5);
        check_val("rstval p1", p1, 8'h3C);
        check_val("rstval p2", p2, 8'h81);

        @(negedge clk);
        rst_n = 1'b1; d1 = 8'hFF;
        tick();
        check_q("first load", 8'h01, 8'hFF, 8'hF0);
        check_val("first load p1", p1, 8'hFF);

        @(negedge clk);
        d1 = 8'hAA;
        tick();
        check_q("ch1 only", 8'h01, 8'hAA, 8'hF0);

        @(negedge clk);
        d0 = 8'h55;
        #1;
        check_val("hold q0 between edges", q0, 8'h01);
        tick();
        check_q("d0 update", 8'h55, 8'hAA, 8'hF0);

        @(negedge clk);
        rst_n = 1'b0; d0 = 8'hFF; d1 = 8'hFF; d2 = 8'hFF;
        #1;
        check_q("rst before edge", 8'h55, 8'hAA, 8'hF0);
        tick();
        check_q("mid reset", 8'h00, 8'h00, 8'h00);
        check_val("mid reset p0", p0, 8'hA5);
        check_val("mid reset p2", p2, 8'h81);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_q("post release", 8'hFF, 8'hFF, 8'hFF);

        // rst_n pulse fully between edges must have no effect
        rst_n = 1'b0;
        #2;
        check_q("rst glitch low", 8'hFF, 8'hFF, 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        d0 = 8'h12; d1 = 8'h34; d2 = 8'h56;
        tick();
        check_q("after glitch", 8'h12, 8'h34, 8'h56);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d0 = vec[i][0]; d1 = vec[i][1]; d2 = vec[i][2];
            tick();
            check_q($sformatf("vec%0d", i), vec[i][0], vec[i][1], vec[i][2]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
